// File: rtl/sensor_filt_multi.sv
// sensor_filt_multi: NUM_CH independent sensor-input conditioners.
// Each channel synchronises a raw input and deglitches it with a stability
// counter. It emits 1-clk filtered rise/fall pulses and measures the clock
// count between filtered rises, flagging a stall when the period counter
// saturates.
// Optional feature, enabled by defining SENSOR_FILT_GLITCH_CNT_EN: 8-bit
// per-channel counters of pending transitions that aborted before being
// accepted.
module sensor_filt_multi #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int PER_W    = 20,
    parameter int FAST_SIM = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         sig_in,
    output logic [NUM_CH-1:0]         filt,
    output logic [NUM_CH-1:0]         filt_rise,
    output logic [NUM_CH-1:0]         filt_fall,
    output logic [NUM_CH*PER_W-1:0]   period,
    output logic [NUM_CH-1:0]         per_vld,
    output logic [NUM_CH-1:0]         stalled,
    input  logic                      glitch_clr,
    output logic [NUM_CH*8-1:0]       glitch_cnt
);

    localparam logic [CNT_W-1:0] THRESH  = (FAST_SIM != 0) ? CNT_W'(511) : {CNT_W{1'b1}};
    localparam logic [PER_W-1:0] PER_MAX = {PER_W{1'b1}};

    logic [NUM_CH-1:0] r_q1_p0, r_q2_p1, r_q3_p2;
    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic [NUM_CH-1:0] r_filt, r_filt_d;
    logic [NUM_CH-1:0] r_rise, r_fall;
    logic [PER_W-1:0]  r_per_cnt [NUM_CH];
    logic [PER_W-1:0]  r_period [NUM_CH];
    logic [NUM_CH-1:0] r_per_vld, r_stalled, r_armed;

    // Three-flop synchroniser; q3 is the first stage safe to compare against q2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q1_p0 <= '0;
            r_q2_p1 <= '0;
            r_q3_p2 <= '0;
        end else begin
            r_q1_p0 <= sig_in;
            r_q2_p1 <= r_q1_p0;
            r_q3_p2 <= r_q2_p1;
        end
    end

    // Stability counter restarts on any change and saturates; a full count commits q3 to filt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
            r_filt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_q2_p1[i] != r_q3_p2[i])
                    r_cnt[i] <= '0;
                else if (r_cnt[i] != THRESH)
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                if (r_cnt[i] == THRESH)
                    r_filt[i] <= r_q3_p2[i];
            end
        end
    end

    // Registered edge pulses from filt against its one-cycle delayed copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_d <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
        end else begin
            r_filt_d <= r_filt;
            r_rise   <= r_filt & ~r_filt_d;
            r_fall   <= ~r_filt & r_filt_d;
        end
    end

    // Period measurement: a rise reports only when armed and the counter has not saturated;
    // otherwise it just re-arms. Saturation without a rise declares a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_per_cnt[i] <= '0;
                r_period[i]  <= '0;
            end
            r_per_vld <= '0;
            r_stalled <= '0;
            r_armed   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_per_vld[i] <= 1'b0;
                if (r_rise[i]) begin
                    r_per_cnt[i] <= '0;
                    if (r_armed[i] && !r_stalled[i] && (r_per_cnt[i] != PER_MAX)) begin
                        r_period[i]  <= r_per_cnt[i] + PER_W'(1);
                        r_per_vld[i] <= 1'b1;
                    end else begin
                        r_armed[i]   <= 1'b1;
                        r_stalled[i] <= 1'b0;
                    end
                end else if (r_per_cnt[i] == PER_MAX) begin
                    r_stalled[i] <= 1'b1;
                    r_period[i]  <= PER_MAX;
                    r_armed[i]   <= 1'b0;
                end else begin
                    r_per_cnt[i] <= r_per_cnt[i] + PER_W'(1);
                end
            end
        end
    end

    assign filt      = r_filt;
    assign filt_rise = r_rise;
    assign filt_fall = r_fall;
    assign per_vld   = r_per_vld;
    assign stalled   = r_stalled;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_per
        assign period[g*PER_W +: PER_W] = r_period[g];
    end

`ifdef SENSOR_FILT_GLITCH_CNT_EN
    logic [7:0] r_glitch [NUM_CH];

    // Count pending transitions (q3 differs from filt, run already started) that abort; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) r_glitch[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (glitch_clr)
                    r_glitch[i] <= '0;
                else if ((r_q2_p1[i] != r_q3_p2[i]) && (r_cnt[i] != '0) &&
                         (r_q3_p2[i] != r_filt[i]) && (r_glitch[i] != 8'hFF))
                    r_glitch[i] <= r_glitch[i] + 8'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_gl
        assign glitch_cnt[g*8 +: 8] = r_glitch[g];
    end
`else
    logic w_unused_glitch_clr;
    assign w_unused_glitch_clr = glitch_clr;
    assign glitch_cnt          = '0;
`endif

endmodule
